// File: rtl/dcache_ctrl_if.sv
// ============================================================================
// Module   : dcache_ctrl_if
// Brief    : CPU-side and memory-side buses of the direct-mapped data cache.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dcache_ctrl_if;
  logic         cpu_req_i;
  logic         cpu_write_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  // The cache controller itself
  modport slave (
    input  cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  // The pipeline and memory surrounding the cache
  modport master (
    output cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

`default_nettype wire

// File: rtl/dcache_ctrl.sv
// ============================================================================
// Module   : dcache_ctrl
// Brief    : 16-line direct-mapped, write-back, write-allocate data cache.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_ctrl (
  input  wire logic    clk_i,
  input  wire logic    rst_i,
  dcache_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    MISS       = 3'd1,
    WRITEBACK  = 3'd2,
    READMISS   = 3'd3,
    READMISSOK = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [15:0]  r_valid;
  logic [15:0]  r_dirty;
  logic [22:0]  r_tag  [16];
  logic [255:0] r_data [16];

  logic [22:0]  w_req_tag;
  logic [3:0]   w_index;
  logic [2:0]   w_word;
  logic [7:0]   w_bit_ofs;
  logic [255:0] w_line;
  logic [31:0]  w_rd_word;
  logic         w_hit;
  logic         w_store_hit;
  logic         w_fill;
  logic         w_unused_addr;

  assign w_req_tag     = bus.cpu_addr_i[31:9];
  assign w_index       = bus.cpu_addr_i[8:5];
  assign w_word        = bus.cpu_addr_i[4:2];
  assign w_bit_ofs     = {w_word, 5'b0};
  assign w_unused_addr = &{1'b0, bus.cpu_addr_i[1:0]};

  assign w_line    = r_data[w_index];
  assign w_rd_word = w_line[w_bit_ofs +: 32];

  assign w_hit = bus.cpu_req_i && (r_state == IDLE) && r_valid[w_index]
                 && (r_tag[w_index] == w_req_tag);
  assign w_store_hit = w_hit && bus.cpu_write_i;
  assign w_fill      = (r_state == READMISS) && bus.mem_ack_i;

  assign bus.cpu_stall_o = (bus.cpu_req_i && !w_hit) || (r_state != IDLE);
  assign bus.cpu_data_o  = (w_hit && !bus.cpu_write_i) ? w_rd_word : 32'h0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Only the line status bits need reset; tags and data are qualified by valid.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (w_fill) begin
      r_valid[w_index] <= 1'b1;
      r_dirty[w_index] <= 1'b0;
    end else if (w_store_hit) begin
      r_dirty[w_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_fill) begin
      r_data[w_index] <= bus.mem_data_i;
      r_tag[w_index]  <= w_req_tag;
    end else if (w_store_hit) begin
      r_data[w_index][w_bit_ofs +: 32] <= bus.cpu_data_i;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    bus.mem_enable_o = 1'b0;
    bus.mem_write_o  = 1'b0;
    bus.mem_addr_o   = 32'h0;
    bus.mem_data_o   = 256'h0;
    case (r_state)
      IDLE: begin
        if (bus.cpu_req_i && !w_hit) begin
          w_state_nxt = MISS;
        end
      end
      MISS: begin
        if (r_valid[w_index] && r_dirty[w_index]) begin
          w_state_nxt = WRITEBACK;
        end else begin
          w_state_nxt = READMISS;
        end
      end
      WRITEBACK: begin
        bus.mem_enable_o = 1'b1;
        bus.mem_write_o  = 1'b1;
        bus.mem_addr_o   = {r_tag[w_index], w_index, 5'b0};
        bus.mem_data_o   = w_line;
        if (bus.mem_ack_i) begin
          w_state_nxt = READMISS;
        end
      end
      READMISS: begin
        bus.mem_enable_o = 1'b1;
        bus.mem_addr_o   = {w_req_tag, w_index, 5'b0};
        if (bus.mem_ack_i) begin
          w_state_nxt = READMISSOK;
        end
      end
      READMISSOK: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
// ============================================================================
// Module   : tb_dcache_ctrl
// Brief    : Directed self-checking bench for dcache_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_ctrl;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk_i = ~clk_i;

  dcache_ctrl_if bus ();

  dcache_ctrl u_dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [255:0] mk_block(input logic [31:0] base);
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[i*32 +: 32] = base + i;
    return b;
  endfunction

  // Wait for a memory request, check it, then acknowledge it one cycle later.
  task automatic mem_txn(input string tag, input logic exp_wr, input logic [31:0] exp_addr,
                         input logic [255:0] fill, input int wi, input logic [31:0] wv);
    bit got;
    logic [255:0] d;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #2;
      if (bus.mem_enable_o) begin
        got = 1'b1;
        break;
      end
      step();
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: observed no mem_enable_o, expected a request", tag);
      return;
    end
    check({tag, "_write"}, bus.mem_write_o, exp_wr);
    check({tag, "_addr"}, bus.mem_addr_o, exp_addr);
    if (exp_wr) begin
      d = bus.mem_data_o;
      check({tag, "_wbdata"}, d[wi*32 +: 32], wv);
    end
    step();
    bus.mem_ack_i  = 1'b1;
    bus.mem_data_i = fill;
    step();
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.cpu_req_i   = 1'b0;
    bus.cpu_write_i = 1'b0;
    bus.cpu_addr_i  = 32'h0;
    bus.cpu_data_i  = 32'h0;
    bus.mem_data_i  = '0;
    bus.mem_ack_i   = 1'b0;

    // Reset state
    step();
    step();
    #2;
    check("rst_stall", bus.cpu_stall_o, 1'b0);
    check("rst_mem_en", bus.mem_enable_o, 1'b0);
    check("rst_cpu_data", bus.cpu_data_o, 32'h0);
    bus.cpu_req_i  = 1'b1;
    bus.cpu_addr_i = 32'h44;
    #1;
    check("rst_req_stall", bus.cpu_stall_o, 1'b1);
    check("rst_req_mem_addr", bus.mem_addr_o, 32'h0);
    bus.cpu_req_i = 1'b0;
    step();
    rst_i = 1'b1;

    // Cold load miss
    step();
    bus.cpu_req_i   = 1'b1;
    bus.cpu_write_i = 1'b0;
    bus.cpu_addr_i  = 32'h44;
    #2;
    check("cold_idle_stall", bus.cpu_stall_o, 1'b1);
    check("cold_idle_data", bus.cpu_data_o, 32'h0);
    step();
    mem_txn("cold_rd", 1'b0, 32'h40, mk_block(32'hDEADBEEE), 0, 32'h0);
    #2;
    check("cold_rmok_stall", bus.cpu_stall_o, 1'b1);
    check("cold_rmok_mem_en", bus.mem_enable_o, 1'b0);
    step();
    #2;
    check("cold_hit_stall", bus.cpu_stall_o, 1'b0);
    check("cold_hit_data", bus.cpu_data_o, 32'hDEADBEEF);

    // Store hit, then load back
    step();
    bus.cpu_write_i = 1'b1;
    bus.cpu_data_i  = 32'h12345678;
    #2;
    check("st_hit_stall", bus.cpu_stall_o, 1'b0);
    step();
    bus.cpu_write_i = 1'b0;
    #2;
    check("ld_after_st_stall", bus.cpu_stall_o, 1'b0);
    check("ld_after_st_data", bus.cpu_data_o, 32'h12345678);

    // Conflict miss on dirty line
    step();
    bus.cpu_addr_i = 32'h244;
    #2;
    check("conf_stall", bus.cpu_stall_o, 1'b1);
    step();
    mem_txn("conf_wb", 1'b1, 32'h40, '0, 1, 32'h12345678);
    mem_txn("conf_rd", 1'b0, 32'h240, mk_block(32'h0BADF000), 0, 32'h0);
    #2;
    step();
    #2;
    check("conf_hit_data", bus.cpu_data_o, 32'h0BADF001);

    // Store miss to a clean line allocates and merges
    step();
    bus.cpu_write_i = 1'b1;
    bus.cpu_addr_i  = 32'h1008;
    bus.cpu_data_i  = 32'hA5A5A5A5;
    #2;
    check("stm_stall", bus.cpu_stall_o, 1'b1);
    step();
    mem_txn("stm_rd", 1'b0, 32'h1000, mk_block(32'h30000000), 0, 32'h0);
    step();
    #2;
    check("stm_merge_stall", bus.cpu_stall_o, 1'b0);
    step();
    bus.cpu_write_i = 1'b0;
    #2;
    check("stm_ld_data", bus.cpu_data_o, 32'hA5A5A5A5);
    step();
    bus.cpu_addr_i = 32'h1004;
    #2;
    check("stm_other_word", bus.cpu_data_o, 32'h30000001);
    step();
    bus.cpu_addr_i = 32'h8;
    #2;
    check("evict_stall", bus.cpu_stall_o, 1'b1);
    step();
    mem_txn("evict_wb", 1'b1, 32'h1000, '0, 2, 32'hA5A5A5A5);
    mem_txn("evict_rd", 1'b0, 32'h0, mk_block(32'h40000000), 0, 32'h0);
    step();
    #2;
    check("evict_hit_data", bus.cpu_data_o, 32'h40000002);

    // Reset in READMISS, late ack ignored
    step();
    bus.cpu_addr_i = 32'h364;
    step();
    step();
    #2;
    check("mid_rm_mem_en", bus.mem_enable_o, 1'b1);
    rst_i = 1'b0;
    #1;
    check("mid_rst_mem_en", bus.mem_enable_o, 1'b0);
    check("mid_rst_stall", bus.cpu_stall_o, 1'b1);
    step();
    rst_i         = 1'b1;
    bus.cpu_req_i = 1'b0;
    bus.mem_ack_i = 1'b1;
    step();
    bus.mem_ack_i = 1'b0;
    #2;
    check("late_ack_stall", bus.cpu_stall_o, 1'b0);
    check("late_ack_mem_en", bus.mem_enable_o, 1'b0);
    step();
    bus.cpu_req_i = 1'b1;
    #2;
    check("reload_stall", bus.cpu_stall_o, 1'b1);
    step();
    #2;
    check("reload_miss_mem_en", bus.mem_enable_o, 1'b0);
    mem_txn("reload_rd", 1'b0, 32'h360, mk_block(32'hC0DE0000), 0, 32'h0);
    step();

    // Back-to-back hits across one line
    for (int i = 0; i < 8; i++) begin
      bus.cpu_addr_i = 32'h360 + 32'(i * 4);
      #2;
      check("b2b_stall", bus.cpu_stall_o, 1'b0);
      check("b2b_data", bus.cpu_data_o, 32'hC0DE0000 + 32'(i));
      step();
    end
    bus.cpu_req_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
